wdata_channel: RTL and testbench

AXI write data and write response engine for the encoder result path. It drains 1024-bit result beats from a show-ahead output FIFO and emits fixed-length W bursts with WLAST. It accepts B responses, limits outstanding bursts and reports completion and errors to the job controller. It is the write-side counterpart of the read data channel and sits between the output FIFO and the AXI master port.

---
 rtl/wdata_pkg.sv | 24 ++
 rtl/wr_outstanding_cnt.sv | 35 +++
 rtl/wdata_channel.sv | 201 ++++++++++++++++++++
 tb/tb_wdata_channel.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wdata_pkg.sv
// Shared types and constants for the AXI write data / response engine.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wdata_pkg;

    localparam int DATA_W = 1024;
    localparam int STRB_W = DATA_W / 8;
    localparam int BCNT_W = 16;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT_B = 2'd2,
        DONE   = 2'd3
    } wr_state_t;

    // Index width for a counter that runs 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wr_outstanding_cnt.sv
// Tracks bursts fully sent on W but not yet answered on B.
// Latency: count updates one cycle after inc/dec; full and underflow are combinational.
// Backpressure: none; a dec with nothing outstanding is flagged and does not wrap.
module wr_outstanding_cnt #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             underflow
);

    // A response with no matching sent burst; a same-cycle send covers it.
    assign underflow = dec && !inc && (count == '0);
    assign full      = (count == CNT_W'(MAX_OUTSTANDING));

    // Up/down counter; a simultaneous send and response leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + CNT_W'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/wdata_channel.sv
// Drains result beats from a show-ahead FIFO into fixed-length AXI W bursts and collects B responses.
// Latency: FIFO non-empty to m_axi_wvalid is 1 cycle; 1 beat/cycle sustained while m_axi_wready=1.
// Backpressure: one registered beat held stable under !wready; new bursts stall at the outstanding limit.
module wdata_channel
    import wdata_pkg::*;
#(
    parameter int ID_WIDTH        = 2,
    parameter int BURST_BEATS     = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [STRB_W-1:0]   m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [ID_WIDTH-1:0] m_axi_bid,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    input  logic                start_pulse,
    input  logic [BCNT_W-1:0]   total_bursts,
    input  logic [DATA_W-1:0]   out_fifo_dout,
    input  logic                out_fifo_empty,
    output logic                out_fifo_rd,
    output logic                wr_error,
    output logic                wr_done
);

    localparam int BEAT_W = idx_width(BURST_BEATS);

    wr_state_t         state;
    logic [BCNT_W-1:0] total_q;
    logic [BCNT_W-1:0] ld_burst;
    logic [BCNT_W-1:0] sent_bursts;
    logic [BCNT_W-1:0] resp_cnt;
    logic [BCNT_W-1:0] ob_count;
    logic [BCNT_W-1:0] unsent;
    logic [BCNT_W-1:0] outstanding_eff;
    logic [BEAT_W-1:0] ld_beat;

    logic ob_full;
    logic ob_underflow;
    logic start_acc;
    logic last_beat;
    logic final_beat;
    logic launch_block;
    logic load;
    logic w_hs;
    logic burst_sent;
    logic b_hs;
    logic b_active;
    logic b_count;
    logic b_err;
    logic unused_bid;

    // Response ID carries no meaning here: every burst uses the same ID.
    assign unused_bid = ^m_axi_bid;

    assign start_acc  = (state == IDLE) && start_pulse;
    assign last_beat  = (ld_beat == BEAT_W'(BURST_BEATS - 1));
    assign final_beat = last_beat && (ld_burst == total_q - BCNT_W'(1));

    // Bursts completely loaded but whose WLAST has not yet handshaken; together
    // with the sent-but-unanswered count this is what a new burst would join.
    assign unsent          = ld_burst - sent_bursts;
    assign outstanding_eff = ob_count + unsent;
    assign launch_block    = (ld_beat == '0) &&
                             (ob_full || (outstanding_eff >= BCNT_W'(MAX_OUTSTANDING)));

    assign load = (state == SEND) && !out_fifo_empty &&
                  (!m_axi_wvalid || m_axi_wready) && !launch_block;
    assign out_fifo_rd = load;

    assign w_hs       = m_axi_wvalid && m_axi_wready;
    assign burst_sent = w_hs && m_axi_wlast;
    assign b_hs       = m_axi_bvalid && m_axi_bready;
    assign b_active   = b_hs && ((state == SEND) || (state == WAIT_B));
    assign b_count    = b_active && !ob_underflow;
    assign b_err      = b_active && ((m_axi_bresp != RESP_OKAY) || ob_underflow);

    wr_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (BCNT_W)
    ) u_outstanding (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_acc),
        .inc       (burst_sent),
        .dec       (b_active),
        .count     (ob_count),
        .full      (ob_full),
        .underflow (ob_underflow)
    );

    // Job sequencing plus the registered done pulse and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            total_q  <= '0;
            wr_done  <= 1'b0;
            wr_error <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_pulse) begin
                        total_q <= total_bursts;
                        if (total_bursts == '0) begin
                            state   <= DONE;
                            wr_done <= 1'b1;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (load && final_beat) begin
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (!m_axi_wvalid && (resp_cnt == total_q)) begin
                        state   <= DONE;
                        wr_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (start_acc) begin
                wr_error <= 1'b0;
            end else if (b_err) begin
                wr_error <= 1'b1;
            end
        end
    end

    // Beat/burst load position and sent/answered burst counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_beat     <= '0;
            ld_burst    <= '0;
            sent_bursts <= '0;
            resp_cnt    <= '0;
        end else if (start_acc) begin
            ld_beat     <= '0;
            ld_burst    <= '0;
            sent_bursts <= '0;
            resp_cnt    <= '0;
        end else begin
            if (load) begin
                if (last_beat) begin
                    ld_beat  <= '0;
                    ld_burst <= ld_burst + BCNT_W'(1);
                end else begin
                    ld_beat <= ld_beat + BEAT_W'(1);
                end
            end
            if (burst_sent) begin
                sent_bursts <= sent_bursts + BCNT_W'(1);
            end
            if (b_count) begin
                resp_cnt <= resp_cnt + BCNT_W'(1);
            end
        end
    end

    // Single-entry W output register; contents only change on a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axi_wdata  <= '0;
            m_axi_wstrb  <= '0;
            m_axi_wlast  <= 1'b0;
            m_axi_wvalid <= 1'b0;
        end else if (load) begin
            m_axi_wdata  <= out_fifo_dout;
            m_axi_wstrb  <= '1;
            m_axi_wlast  <= last_beat;
            m_axi_wvalid <= 1'b1;
        end else if (w_hs) begin
            m_axi_wvalid <= 1'b0;
        end
    end

    // B channel is always ready once out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axi_bready <= 1'b0;
        end else begin
            m_axi_bready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wdata_channel.sv
// Randomized bench for wdata_channel against a queue-based model of the W/B job protocol.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: wready, FIFO gaps and B timing randomized per job.
module tb_wdata_channel;

    localparam int BB = 4;
    localparam int MO = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1023:0]  m_axi_wdata;
    logic [127:0]   m_axi_wstrb;
    logic           m_axi_wlast;
    logic           m_axi_wvalid;
    logic           m_axi_wready;
    logic [1:0]     m_axi_bid;
    logic [1:0]     m_axi_bresp;
    logic           m_axi_bvalid;
    logic           m_axi_bready;
    logic           start_pulse;
    logic [15:0]    total_bursts;
    logic [1023:0]  out_fifo_dout;
    logic           out_fifo_empty;
    logic           out_fifo_rd;
    logic           wr_error;
    logic           wr_done;

    int checks   = 0;
    int failures = 0;

    logic [1023:0] fifo_q[$];
    logic [1023:0] exp_q[$];

    wdata_channel #(
        .ID_WIDTH        (2),
        .BURST_BEATS     (BB),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m_axi_wdata    (m_axi_wdata),
        .m_axi_wstrb    (m_axi_wstrb),
        .m_axi_wlast    (m_axi_wlast),
        .m_axi_wvalid   (m_axi_wvalid),
        .m_axi_wready   (m_axi_wready),
        .m_axi_bid      (m_axi_bid),
        .m_axi_bresp    (m_axi_bresp),
        .m_axi_bvalid   (m_axi_bvalid),
        .m_axi_bready   (m_axi_bready),
        .start_pulse    (start_pulse),
        .total_bursts   (total_bursts),
        .out_fifo_dout  (out_fifo_dout),
        .out_fifo_empty (out_fifo_empty),
        .out_fifo_rd    (out_fifo_rd),
        .wr_error       (wr_error),
        .wr_done        (wr_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (low 256b)", tag, got[255:0], exp[255:0]);
        end
    endtask

    function automatic logic [1023:0] rand1024();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic idle_cycles(input int n);
        start_pulse    = 1'b0;
        total_bursts   = '0;
        m_axi_wready   = 1'b0;
        m_axi_bvalid   = 1'b0;
        m_axi_bresp    = 2'b00;
        m_axi_bid      = 2'b00;
        out_fifo_empty = 1'b1;
        out_fifo_dout  = '0;
        repeat (n) @(negedge clk);
    endtask

    // One job: nb bursts, err_burst = index of the burst answered with SLVERR (-1 none),
    // hold_cyc = B withheld until this cycle, restart = stray start_pulse mid-job,
    // abort_beats = return early after this many accepted beats (0 = run to completion).
    task automatic run_job(input int nb, input int err_burst, input int rdy_pct, input int gap_pct,
                           input int b_pct, input int hold_cyc, input bit seq, input bit restart,
                           input int abort_beats);
        int cyc, beats, sent_b, acked, done_due, first_b;
        bit prev_stall;
        logic [1023:0] pw, d;
        logic pl;
        fifo_q.delete();
        exp_q.delete();
        for (int i = 0; i < nb * BB; i++) begin
            d = seq ? 1024'(i + 1) : rand1024();
            fifo_q.push_back(d);
            exp_q.push_back(d);
        end
        cyc = 0; beats = 0; sent_b = 0; acked = 0; first_b = -1;
        prev_stall = 1'b0; pw = '0; pl = 1'b0;
        done_due = (nb == 0) ? 1 : -1;
        while (1) begin
            start_pulse    = (cyc == 0) || (restart && cyc == 6);
            total_bursts   = (cyc == 0) ? 16'(nb) : 16'd7;
            out_fifo_empty = (fifo_q.size() == 0) || (int'($urandom_range(99)) < gap_pct);
            out_fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
            m_axi_wready   = (int'($urandom_range(99)) < rdy_pct);
            m_axi_bvalid   = (cyc >= hold_cyc) && (sent_b > acked) && (int'($urandom_range(99)) < b_pct);
            m_axi_bresp    = (acked == err_burst) ? 2'b10 : 2'b00;
            m_axi_bid      = 2'($urandom);
            #1;
            if (hold_cyc > 0 && cyc == hold_cyc) begin
                check("limit_beats", beats, MO * BB);
                check("limit_wvalid", m_axi_wvalid, 0);
            end
            if (hold_cyc > 0 && first_b >= 0 && cyc == first_b + 1)
                check("relaunch_rd", out_fifo_rd, 1);
            if (prev_stall) begin
                check("stall_wvalid", m_axi_wvalid, 1);
                check("stall_wdata", m_axi_wdata, pw);
                check("stall_wlast", m_axi_wlast, pl);
            end
            prev_stall = m_axi_wvalid && !m_axi_wready;
            pw = m_axi_wdata;
            pl = m_axi_wlast;
            if (out_fifo_rd) begin
                check("rd_when_empty", out_fifo_empty, 0);
                if (!out_fifo_empty) d = fifo_q.pop_front();
            end
            if (m_axi_wvalid && m_axi_wready) begin
                check("wlast", m_axi_wlast, (beats % BB) == BB - 1);
                check("wstrb", m_axi_wstrb, {128{1'b1}});
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    d = exp_q.pop_front();
                    check("wdata", m_axi_wdata, d);
                end
                beats++;
                if (m_axi_wlast) begin
                    sent_b++;
                    check("outstanding_limit", (sent_b - acked) <= MO, 1);
                end
            end
            if (m_axi_bvalid && m_axi_bready) begin
                acked++;
                if (first_b < 0) first_b = cyc;
                if (acked == nb) done_due = cyc + 2;
            end
            if (abort_beats > 0 && beats >= abort_beats) return;
            if (cyc == 1) check("err_cleared_on_start", wr_error, 0);
            check("wr_done", wr_done, cyc == done_due);
            if (done_due >= 0 && cyc >= done_due)
                check("wr_error", wr_error, (err_burst >= 0) && (err_burst < nb));
            if (done_due >= 0 && cyc == done_due + 1) break;
            if (cyc > 4000) begin
                check("job_timeout", 0, 1);
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check("beat_count", beats, nb * BB);
        check("fifo_drained", fifo_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_cycles(2);
        #1;
        check("rst_wvalid", m_axi_wvalid, 0);
        check("rst_wlast", m_axi_wlast, 0);
        check("rst_wdata", m_axi_wdata, 0);
        check("rst_wstrb", m_axi_wstrb, 0);
        check("rst_bready", m_axi_bready, 0);
        check("rst_fifo_rd", out_fifo_rd, 0);
        check("rst_wr_error", wr_error, 0);
        check("rst_wr_done", wr_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("bready_after_rst", m_axi_bready, 1);
        idle_cycles(1);

        // Basic in-order job with sequential payload.
        run_job(2, -1, 100, 0, 100, 0, 1'b1, 1'b0, 0);
        idle_cycles(2);
        // Backpressure on W plus FIFO gaps.
        run_job(2, -1, 50, 25, 60, 0, 1'b0, 1'b0, 0);
        idle_cycles(2);
        // Outstanding limit: B withheld, then released.
        run_job(4, -1, 100, 0, 100, 40, 1'b0, 1'b0, 0);
        idle_cycles(2);
        // Error response on burst 1, with a stray start mid-job.
        run_job(3, 1, 80, 10, 50, 0, 1'b0, 1'b1, 0);
        idle_cycles(2);
        // Next start clears the error.
        run_job(2, -1, 70, 10, 70, 0, 1'b0, 1'b0, 0);
        idle_cycles(2);
        // Zero-length job.
        run_job(0, -1, 100, 0, 100, 0, 1'b0, 1'b0, 0);
        idle_cycles(2);

        // B arriving while idle is ignored.
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'b10;
        @(negedge clk);
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        #1;
        check("idle_b_no_error", wr_error, 0);
        check("idle_b_no_done", wr_done, 0);
        idle_cycles(1);

        // Randomized jobs.
        for (int j = 0; j < 6; j++) begin
            int nb, eb;
            nb = int'($urandom_range(5, 1));
            eb = ($urandom_range(2) == 0) ? int'($urandom_range(nb - 1)) : -1;
            run_job(nb, eb, int'($urandom_range(100, 30)), int'($urandom_range(40)),
                    int'($urandom_range(100, 20)), 0, 1'b0, nb > 1, 0);
            idle_cycles(int'($urandom_range(3, 1)));
        end

        // Asynchronous reset mid-burst after an error has been latched.
        run_job(3, 0, 100, 0, 100, 0, 1'b0, 1'b0, 6);
        check("pre_rst_error", wr_error, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_wvalid", m_axi_wvalid, 0);
        check("midrst_wlast", m_axi_wlast, 0);
        check("midrst_wr_done", wr_done, 0);
        check("midrst_wr_error", wr_error, 0);
        check("midrst_fifo_rd", out_fifo_rd, 0);
        check("midrst_bready", m_axi_bready, 0);
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(2);
        run_job(2, -1, 75, 15, 60, 0, 1'b0, 1'b0, 0);
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
